// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination-lock entry controller.
//   - state_t     : controller state encoding
//   - digits_t    : four packed hex digits, index 3 = leftmost (disp3)
//   - LOCK_DIGIT  : value shown on every digit while locked out
//   - fill_digits : replicate one digit across the whole display
package combo_lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [DIGIT_W-1:0] LOCK_DIGIT = 4'hE;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  function automatic digits_t fill_digits(input logic [DIGIT_W-1:0] d);
    digits_t r;
    for (int i = 0; i < NUM_DIGITS; i++) r[i] = d;
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced, clk-synchronous button.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : qualifies the edge output (history still tracks when low)
//   level      : button level
//   rise       : one-cycle pulse, level high now and low on the previous clk
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev & en;

endmodule

// File: rtl/combo_entry_fsm.sv
// Combination-lock entry controller driving a four-digit hex display.
// Ports:
//   clk, rst                  : clock, async active-low reset
//   btnInc/btnDec             : step the digit under the cursor up/down (mod 16)
//   btnEnter                  : advance cursor, or submit the code on the last digit
//   btnClear                  : zero the entry (also leaves OPEN)
//   disp3..disp0              : registered digits for the seven-segment driver
//   cursor                    : digit being edited, 0 = disp3 .. 3 = disp0
//   unlocked / lockedOut      : registered status, high in OPEN / LOCKOUT
//
// state   | meaning
// --------+--------------------------------------------------------------
// ENTRY   | user edits digits; enter on the last digit submits the code
// CHECK   | one cycle: compare digits with CODE, buttons ignored
// OPEN    | code accepted; only clear does anything (back to ENTRY)
// LOCKOUT | too many wrong codes; display EEEE, all buttons ignored
module combo_entry_fsm
  import combo_lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h3210,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnInc,
  input  logic       btnDec,
  input  logic       btnEnter,
  input  logic       btnClear,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [1:0] cursor,
  output logic       unlocked,
  output logic       lockedOut
);

  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int LCNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  state_t              state, state_nxt;
  digits_t             digs, digs_nxt;
  logic [1:0]          cur, cur_nxt;
  logic [TRY_W-1:0]    tries, tries_nxt;
  logic [LCNT_W-1:0]   lcnt, lcnt_nxt;
  logic                unl_q, unl_nxt;
  logic                lck_q, lck_nxt;
  logic                run;
  logic                inc_e, dec_e, ent_e, clr_e;

  // run is low for the first clk after reset. Edges seen on that clk are
  // discarded so a button already held when reset releases is only latched
  // into history and needs a fresh low-to-high transition to act.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  btn_edge u_edge_inc (.clk(clk), .rst_n(rst), .en(run), .level(btnInc),   .rise(inc_e));
  btn_edge u_edge_dec (.clk(clk), .rst_n(rst), .en(run), .level(btnDec),   .rise(dec_e));
  btn_edge u_edge_ent (.clk(clk), .rst_n(rst), .en(run), .level(btnEnter), .rise(ent_e));
  btn_edge u_edge_clr (.clk(clk), .rst_n(rst), .en(run), .level(btnClear), .rise(clr_e));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ENTRY;
      digs  <= '0;
      cur   <= '0;
      tries <= '0;
      lcnt  <= '0;
      unl_q <= 1'b0;
      lck_q <= 1'b0;
    end else begin
      state <= state_nxt;
      digs  <= digs_nxt;
      cur   <= cur_nxt;
      tries <= tries_nxt;
      lcnt  <= lcnt_nxt;
      unl_q <= unl_nxt;
      lck_q <= lck_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    digs_nxt  = digs;
    cur_nxt   = cur;
    tries_nxt = tries;
    lcnt_nxt  = lcnt;
    case (state)
      ENTRY: begin
        if (clr_e) begin
          digs_nxt = '0;
          cur_nxt  = '0;
        end else if (ent_e) begin
          if (cur == 2'd3) state_nxt = CHECK;
          else             cur_nxt   = cur + 2'd1;
        end else if (inc_e && !dec_e) begin
          digs_nxt[2'd3 - cur] = digs[2'd3 - cur] + 4'd1;
        end else if (dec_e && !inc_e) begin
          digs_nxt[2'd3 - cur] = digs[2'd3 - cur] - 4'd1;
        end
      end
      CHECK: begin
        if (digs == CODE) begin
          state_nxt = OPEN;
          tries_nxt = '0;
        end else if (int'(tries) + 1 >= MAX_TRIES) begin
          state_nxt = LOCKOUT;
          tries_nxt = TRY_W'(MAX_TRIES);
          digs_nxt  = fill_digits(LOCK_DIGIT);
          lcnt_nxt  = LCNT_W'(LOCKOUT_CYCLES - 1);
        end else begin
          state_nxt = ENTRY;
          tries_nxt = tries + TRY_W'(1);
          digs_nxt  = '0;
          cur_nxt   = '0;
        end
      end
      OPEN: begin
        if (clr_e) begin
          state_nxt = ENTRY;
          digs_nxt  = '0;
          cur_nxt   = '0;
        end
      end
      LOCKOUT: begin
        // Counter loads LOCKOUT_CYCLES-1 and exits on the edge after it hits
        // zero, giving exactly LOCKOUT_CYCLES cycles in this state.
        if (lcnt == '0) begin
          state_nxt = ENTRY;
          digs_nxt  = '0;
          cur_nxt   = '0;
          tries_nxt = '0;
        end else begin
          lcnt_nxt = lcnt - LCNT_W'(1);
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  // Status flags are registered from the next state so they line up with it
  always_comb begin
    unl_nxt = (state_nxt == OPEN);
    lck_nxt = (state_nxt == LOCKOUT);
  end

  assign disp3     = digs[3];
  assign disp2     = digs[2];
  assign disp1     = digs[1];
  assign disp0     = digs[0];
  assign cursor    = cur;
  assign unlocked  = unl_q;
  assign lockedOut = lck_q;

endmodule

// File: tb/tb_combo_entry_fsm.sv
module tb_combo_entry_fsm;

  localparam logic [3:0] INC = 4'b0001;
  localparam logic [3:0] DEC = 4'b0010;
  localparam logic [3:0] ENT = 4'b0100;
  localparam logic [3:0] CLR = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btns = 4'h0;
  logic [3:0] disp3, disp2, disp1, disp0;
  logic [1:0] cursor;
  logic       unlocked, lockedOut;
  logic [15:0] dut_disp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] disp;
    logic [1:0]  cur;
    logic        cur_chk;
    logic        unl;
    logic        lck;
  } exp_t;

  typedef struct {
    logic [3:0] btn;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[21];

  combo_entry_fsm #(
    .CODE(16'h3210), .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .btnInc(btns[0]), .btnDec(btns[1]), .btnEnter(btns[2]), .btnClear(btns[3]),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .cursor(cursor), .unlocked(unlocked), .lockedOut(lockedOut)
  );

  assign dut_disp = {disp3, disp2, disp1, disp0};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [15:0] d, input logic [1:0] c,
                              input logic cc, input logic u, input logic l);
    exp_t e;
    e.disp = d; e.cur = c; e.cur_chk = cc; e.unl = u; e.lck = l;
    return e;
  endfunction

  function automatic vec_t mv(input logic [3:0] b, input exp_t e);
    vec_t v;
    v.btn = b; v.e = e;
    return v;
  endfunction

  task automatic push(input logic [15:0] d, input logic [1:0] c,
                      input logic cc, input logic u, input logic l);
    sbq.push_back(mk(d, c, cc, u, l));
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
    end else begin
      e = sbq.pop_front();
      if (dut_disp !== e.disp || (e.cur_chk && cursor !== e.cur) ||
          unlocked !== e.unl || lockedOut !== e.lck) begin
        errors++;
        $display("FAIL %s: got disp=%h cur=%0d unl=%b lck=%b, want disp=%h cur=%0d(chk=%b) unl=%b lck=%b",
                 nm, dut_disp, cursor, unlocked, lockedOut, e.disp, e.cur, e.cur_chk, e.unl, e.lck);
      end
    end
  endtask

  task automatic check_val(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  task automatic press(input logic [3:0] b);
    btns = b;
    @(posedge clk); #1;
    btns = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      btns = vecs[i].btn;
      sbq.push_back(vecs[i].e);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i));
      btns = 4'h0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cnt, bad;
    bit exited;

    // Correct code entry, expected outputs right after each press edge
    vecs[0]  = mv(INC, mk(16'h1000, 2'd0, 1, 0, 0));
    vecs[1]  = mv(INC, mk(16'h2000, 2'd0, 1, 0, 0));
    vecs[2]  = mv(INC, mk(16'h3000, 2'd0, 1, 0, 0));
    vecs[3]  = mv(ENT, mk(16'h3000, 2'd1, 1, 0, 0));
    vecs[4]  = mv(INC, mk(16'h3100, 2'd1, 1, 0, 0));
    vecs[5]  = mv(INC, mk(16'h3200, 2'd1, 1, 0, 0));
    vecs[6]  = mv(ENT, mk(16'h3200, 2'd2, 1, 0, 0));
    vecs[7]  = mv(INC, mk(16'h3210, 2'd2, 1, 0, 0));
    vecs[8]  = mv(ENT, mk(16'h3210, 2'd3, 1, 0, 0));
    vecs[9]  = mv(ENT, mk(16'h3210, 2'd3, 1, 0, 0));
    // OPEN: inc/enter ignored, clear returns to ENTRY
    vecs[10] = mv(INC, mk(16'h3210, 2'd0, 0, 1, 0));
    vecs[11] = mv(ENT, mk(16'h3210, 2'd0, 0, 1, 0));
    vecs[12] = mv(CLR, mk(16'h0000, 2'd0, 1, 0, 0));
    // Wrap, conflict and priority
    vecs[13] = mv(DEC,             mk(16'hF000, 2'd0, 1, 0, 0));
    vecs[14] = mv(INC | DEC,       mk(16'hF000, 2'd0, 1, 0, 0));
    vecs[15] = mv(INC,             mk(16'h0000, 2'd0, 1, 0, 0));
    vecs[16] = mv(ENT | INC,       mk(16'h0000, 2'd1, 1, 0, 0));
    vecs[17] = mv(INC,             mk(16'h0100, 2'd1, 1, 0, 0));
    vecs[18] = mv(DEC,             mk(16'h0000, 2'd1, 1, 0, 0));
    vecs[19] = mv(DEC,             mk(16'h0F00, 2'd1, 1, 0, 0));
    vecs[20] = mv(CLR | ENT | INC, mk(16'h0000, 2'd0, 1, 0, 0));

    // Reset held low while buttons toggle
    for (int i = 0; i < 4; i++) begin
      btns = i[0] ? 4'hF : 4'h0;
      @(posedge clk); #1;
      push(16'h0000, 2'd0, 1, 0, 0);
      check_out($sformatf("reset_hold%0d", i));
    end

    // Enter held through reset release must not act
    btns = ENT;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("held_at_reset_a");
    @(posedge clk); #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("held_at_reset_b");
    btns = 4'h0;
    @(posedge clk); #1;

    run_vecs(0, 9);
    // CHECK lasts one cycle: unlocked is up by the following edge
    push(16'h3210, 2'd0, 0, 1, 0);
    check_out("open_after_check");
    run_vecs(10, 20);

    // Wrong code #1 with enter held across CHECK -> ENTRY
    press(ENT); press(ENT); press(ENT);
    btns = ENT;
    @(posedge clk); #1;
    push(16'h0000, 2'd3, 1, 0, 0);
    check_out("held_check");
    @(posedge clk); #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("held_reject");
    @(posedge clk); #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("held_no_retrigger");
    btns = 4'h0;
    @(posedge clk); #1;

    // Wrong code #2
    press(ENT); press(ENT); press(ENT); press(ENT);
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("wrong2");

    // Wrong code #3 -> LOCKOUT
    press(ENT); press(ENT); press(ENT);
    btns = ENT;
    @(posedge clk); #1;
    push(16'h0000, 2'd3, 1, 0, 0);
    check_out("wrong3_check");

    cnt = 0; bad = 0; exited = 0;
    for (int i = 0; i < 40 && !exited; i++) begin
      btns = i[0] ? 4'hF : 4'h0;
      @(posedge clk); #1;
      if (lockedOut) begin
        cnt++;
        if (dut_disp !== 16'hEEEE) bad++;
      end else begin
        exited = 1;
      end
    end
    btns = 4'h0;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("lockout_exit");
    check_val("lockout_cycles", cnt, 16);
    check_val("lockout_disp_bad_cycles", bad, 0);

    // Try counter cleared: two wrong codes stay in ENTRY
    press(ENT); press(ENT); press(ENT); press(ENT);
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("post_lock_wrong1");
    press(ENT); press(ENT); press(ENT); press(ENT);
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("post_lock_wrong2");
    press(ENT); press(ENT); press(ENT); press(ENT);
    push(16'hEEEE, 2'd0, 0, 0, 1);
    check_out("relock");

    // Asynchronous reset in mid-LOCKOUT
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("async_reset");
    @(posedge clk); #1;
    push(16'h0000, 2'd0, 1, 0, 0);
    check_out("reset_held");
    rst = 1'b1;
    @(posedge clk); #1;

    check_val("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
